// File: rtl/fp_pkg.sv
// Shared types for the FP writeback path.
// Entry format, register count and arbiter pointer encoding.
package fp_pkg;

  localparam int FP_NREGS  = 32;
  localparam int FP_DATA_W = 32;

  typedef struct packed {
    logic [4:0]           rd;
    logic [FP_DATA_W-1:0] data;
  } fp_wb_t;

  typedef enum logic {
    RR_FPU = 1'b0,
    RR_LSU = 1'b1
  } rr_e;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO of writeback entries.
// Wrapping pointers plus a count register for full/empty.
module fp_wb_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  fp_wb_t data_i,
  output logic   full_o,
  output logic   empty_o,
  output fp_wb_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  fp_wb_t        mem_q [DEPTH];
  logic          push_en;
  logic          pop_en;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  // Next pointers and occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_en) wptr_d = wptr_q + AW'(1);
    if (pop_en)  rptr_d = rptr_q + AW'(1);
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter.
// Round-robin over FPU/LSU FIFOs plus pending-write scoreboard.
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int DATA_W     = FP_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fpu_valid_i,
  output logic              fpu_ready_o,
  input  logic [4:0]        fpu_rd_i,
  input  logic [DATA_W-1:0] fpu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [4:0]        lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_frd_i,
  output logic [31:0]       busy_o,
  output logic              fregwrite_o,
  output logic [4:0]        frd_o,
  output logic [DATA_W-1:0] writeback_data_o
);

  fp_wb_t fpu_in, lsu_in;
  fp_wb_t fpu_head, lsu_head, sel;
  logic   fpu_full, fpu_empty;
  logic   lsu_full, lsu_empty;
  logic   fpu_push, lsu_push;
  logic   fpu_pop, lsu_pop, wb_pop;
  logic   both_v, fpu_only, lsu_only;
  rr_e    rr_q, rr_d;

  logic              fregwrite_q;
  logic [4:0]        frd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [FP_NREGS-1:0] busy_q, busy_d;

  assign fpu_ready_o = !fpu_full;
  assign lsu_ready_o = !lsu_full;
  assign fpu_push    = fpu_valid_i && fpu_ready_o;
  assign lsu_push    = lsu_valid_i && lsu_ready_o;

  assign fpu_in.rd   = fpu_rd_i;
  assign fpu_in.data = fpu_data_i;
  assign lsu_in.rd   = lsu_rd_i;
  assign lsu_in.data = lsu_data_i;

  fp_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fpu_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fpu_push),
    .pop_i  (fpu_pop),
    .data_i (fpu_in),
    .full_o (fpu_full),
    .empty_o(fpu_empty),
    .head_o (fpu_head)
  );

  fp_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (lsu_push),
    .pop_i  (lsu_pop),
    .data_i (lsu_in),
    .full_o (lsu_full),
    .empty_o(lsu_empty),
    .head_o (lsu_head)
  );

  assign both_v   = !fpu_empty && !lsu_empty;
  assign fpu_only = !fpu_empty &&  lsu_empty;
  assign lsu_only =  fpu_empty && !lsu_empty;

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= RR_FPU;
    else         rr_q <= rr_d;
  end

  // Pointer only turns when both sources contend.
  always_comb begin
    rr_d = rr_q;
    if (both_v) rr_d = (rr_q == RR_FPU) ? RR_LSU : RR_FPU;
  end

  // Grant: pick at most one FIFO head per cycle.
  always_comb begin
    fpu_pop = 1'b0;
    lsu_pop = 1'b0;
    unique case (1'b1)
      both_v: begin
        if (rr_q == RR_FPU) fpu_pop = 1'b1;
        else                lsu_pop = 1'b1;
      end
      fpu_only: fpu_pop = 1'b1;
      lsu_only: lsu_pop = 1'b1;
      default: ;
    endcase
  end

  assign wb_pop = fpu_pop || lsu_pop;
  assign sel    = fpu_pop ? fpu_head : lsu_head;

  // Register-file write port; address/data hold when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fregwrite_q <= 1'b0;
      frd_q       <= '0;
      wdata_q     <= '0;
    end else begin
      fregwrite_q <= wb_pop;
      if (wb_pop) begin
        frd_q   <= sel.rd;
        wdata_q <= sel.data;
      end
    end
  end

  assign fregwrite_o      = fregwrite_q;
  assign frd_o            = frd_q;
  assign writeback_data_o = wdata_q;

  // Scoreboard update; a new issue overrides a retiring write.
  always_comb begin
    busy_d = busy_q;
    if (fregwrite_q)   busy_d[frd_q]       = 1'b0;
    if (issue_valid_i) busy_d[issue_frd_i] = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter.
// Vector table plus streaming, fill and reset sequences.
module tb_fp_wb_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        fv, lv, iv;
  logic [4:0]  frd_in, lrd_in, ird;
  logic [31:0] fd, ld;
  logic        fpu_ready_o, lsu_ready_o;
  logic [31:0] busy_o;
  logic        fregwrite_o;
  logic [4:0]  frd_o;
  logic [31:0] writeback_data_o;

  int tests = 0;
  int fails = 0;

  fp_wb_arbiter #(
    .DATA_W    (32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .fpu_valid_i     (fv),
    .fpu_ready_o     (fpu_ready_o),
    .fpu_rd_i        (frd_in),
    .fpu_data_i      (fd),
    .lsu_valid_i     (lv),
    .lsu_ready_o     (lsu_ready_o),
    .lsu_rd_i        (lrd_in),
    .lsu_data_i      (ld),
    .issue_valid_i   (iv),
    .issue_frd_i     (ird),
    .busy_o          (busy_o),
    .fregwrite_o     (fregwrite_o),
    .frd_o           (frd_o),
    .writeback_data_o(writeback_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] busy;
  } vec_t;

  vec_t vq[$];

  int          wr_rd[$];
  logic [31:0] wr_d[$];
  int          wr_cyc[$];
  int          facc[$];
  logic        fr_log[64];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic f_v, input logic [4:0] f_rd,
                     input logic [31:0] f_d, input logic l_v,
                     input logic [4:0] l_rd, input logic [31:0] l_d,
                     input logic i_v, input logic [4:0] i_rd,
                     input logic we, input logic [4:0] wrd,
                     input logic [31:0] wd, input logic [31:0] busy);
    vec_t v;
    v.fv = f_v; v.frd = f_rd; v.fd = f_d;
    v.lv = l_v; v.lrd = l_rd; v.ld = l_d;
    v.iv = i_v; v.ird = i_rd;
    v.we = we; v.wrd = wrd; v.wd = wd; v.busy = busy;
    vq.push_back(v);
  endtask

  task automatic idle_in();
    fv = 0; lv = 0; iv = 0;
    frd_in = 0; lrd_in = 0; ird = 0;
    fd = 0; ld = 0;
  endtask

  task automatic reset_dut();
    idle_in();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic stream(input int nf, input int nl,
                        input int bf, input int bl);
    int   fi;
    int   li;
    int   cyc;
    logic rf;
    logic rl;
    fi = 0; li = 0; cyc = 0;
    wr_rd.delete(); wr_d.delete();
    wr_cyc.delete(); facc.delete();
    for (int k = 0; k < 64; k++) fr_log[k] = 1'bx;
    while (cyc < 40) begin
      fv     = (fi < nf);
      frd_in = 5'(bf + fi);
      fd     = 32'hF000_0000 + 32'(bf + fi);
      lv     = (li < nl);
      lrd_in = 5'(bl + li);
      ld     = 32'hB000_0000 + 32'(bl + li);
      rf     = fpu_ready_o;
      rl     = lsu_ready_o;
      @(posedge clk);
      cyc++;
      #1;
      if (fv && rf) begin
        facc.push_back(cyc);
        fi++;
      end
      if (lv && rl) li++;
      fr_log[cyc] = fpu_ready_o;
      if (fregwrite_o) begin
        wr_rd.push_back(int'(frd_o));
        wr_d.push_back(writeback_data_o);
        wr_cyc.push_back(cyc);
      end
    end
    idle_in();
  endtask

  task automatic chk_order(input string nm, input int exp_rd[],
                           input int nfpu_lo, input int nfpu_hi);
    logic [31:0] ed;
    chk({nm, " count"}, 64'(wr_rd.size()), 64'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size(); k++) begin
      if (exp_rd[k] >= nfpu_lo && exp_rd[k] <= nfpu_hi)
        ed = 32'hF000_0000 + 32'(exp_rd[k]);
      else
        ed = 32'hB000_0000 + 32'(exp_rd[k]);
      if (k < wr_rd.size()) begin
        chk($sformatf("%s rd[%0d]", nm, k), 64'(wr_rd[k]),
            64'(exp_rd[k]));
        chk($sformatf("%s data[%0d]", nm, k), 64'(wr_d[k]), 64'(ed));
      end else begin
        chk($sformatf("%s missing[%0d]", nm, k), 64'hFFFF,
            64'(exp_rd[k]));
      end
    end
  endtask

  initial begin
    int e1[];
    int e2[];
    int nw;

    reset_dut();

    chk("rst fregwrite", 64'(fregwrite_o), 0);
    chk("rst frd", 64'(frd_o), 0);
    chk("rst data", 64'(writeback_data_o), 0);
    chk("rst busy", 64'(busy_o), 0);
    chk("rst fpu_ready", 64'(fpu_ready_o), 1);
    chk("rst lsu_ready", 64'(lsu_ready_o), 1);

    add(1, 5, 32'h3F80_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h3F80_0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h3F80_0000, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 0, 5, 32'h3F80_0000, 32'h80);
    add(1, 7, 32'h4000_0000, 0, 0, 0, 0, 0,
        0, 5, 32'h3F80_0000, 32'h80);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h4000_0000, 32'h80);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h4000_0000, 0);
    add(1, 7, 32'h4040_0000, 0, 0, 0, 0, 0, 0, 7, 32'h4000_0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h4040_0000, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 32'h4040_0000, 32'h80);
    add(0, 0, 0, 1, 7, 32'h1111_1111, 0, 0,
        0, 7, 32'h4040_0000, 32'h80);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1111_1111, 32'h80);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h1111_1111, 0);
    add(1, 9, 32'h99, 1, 10, 32'hAA, 0, 0, 0, 7, 32'h1111_1111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'hAA, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 32'hAA, 0);
    add(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 10, 32'hAA, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 32'h33, 32'h1);
    add(1, 0, 32'h5, 0, 0, 0, 0, 0, 0, 3, 32'h33, 32'h1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h5, 32'h1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 0);

    for (int i = 0; i < vq.size(); i++) begin
      fv = vq[i].fv; frd_in = vq[i].frd; fd = vq[i].fd;
      lv = vq[i].lv; lrd_in = vq[i].lrd; ld = vq[i].ld;
      iv = vq[i].iv; ird = vq[i].ird;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d fregwrite", i), 64'(fregwrite_o),
          64'(vq[i].we));
      chk($sformatf("v%0d frd", i), 64'(frd_o), 64'(vq[i].wrd));
      chk($sformatf("v%0d data", i), 64'(writeback_data_o),
          64'(vq[i].wd));
      chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(vq[i].busy));
      chk($sformatf("v%0d fpu_ready", i), 64'(fpu_ready_o), 1);
      chk($sformatf("v%0d lsu_ready", i), 64'(lsu_ready_o), 1);
    end
    idle_in();

    reset_dut();
    stream(4, 4, 1, 11);
    e1 = '{1, 11, 2, 12, 3, 13, 4, 14};
    chk_order("interleave", e1, 1, 4);
    if (wr_cyc.size() > 0) begin
      chk("interleave first cyc", 64'(wr_cyc[0]), 2);
      for (int k = 1; k < wr_cyc.size(); k++)
        chk($sformatf("interleave gap[%0d]", k),
            64'(wr_cyc[k] - wr_cyc[0]), 64'(k));
    end else begin
      chk("interleave any write", 0, 1);
    end

    reset_dut();
    stream(4, 2, 21, 25);
    e2 = '{21, 25, 22, 26, 23, 24};
    chk_order("fill", e2, 21, 24);
    chk("fill ready c2", 64'(fr_log[2]), 1);
    chk("fill ready c3", 64'(fr_log[3]), 0);
    chk("fill ready c4", 64'(fr_log[4]), 1);
    chk("fill accepts", 64'(facc.size()), 4);
    if (facc.size() == 4) begin
      chk("fill acc0", 64'(facc[0]), 1);
      chk("fill acc2", 64'(facc[2]), 3);
      chk("fill acc3", 64'(facc[3]), 5);
    end

    reset_dut();
    iv = 1; ird = 9;
    fv = 1; frd_in = 1; fd = 32'hF000_0001;
    lv = 1; lrd_in = 2; ld = 32'hB000_0002;
    @(posedge clk);
    #1;
    iv = 0;
    frd_in = 3; fd = 32'hF000_0003;
    lrd_in = 4; ld = 32'hB000_0004;
    @(posedge clk);
    #1;
    idle_in();
    chk("pre-rst fregwrite", 64'(fregwrite_o), 1);
    chk("pre-rst frd", 64'(frd_o), 1);
    chk("pre-rst busy", 64'(busy_o), 64'h200);
    rst_ni = 1'b0;
    #1;
    chk("async fregwrite", 64'(fregwrite_o), 0);
    chk("async frd", 64'(frd_o), 0);
    chk("async data", 64'(writeback_data_o), 0);
    chk("async busy", 64'(busy_o), 0);
    chk("async fpu_ready", 64'(fpu_ready_o), 1);
    chk("async lsu_ready", 64'(lsu_ready_o), 1);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    nw = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (fregwrite_o) nw++;
    end
    chk("post-rst stale writes", 64'(nw), 0);
    chk("post-rst busy", 64'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
